// File: rtl/rr_bus_mux.sv
// rr_bus_mux: NCH-to-1 registered bus mux with valid/ready handshake.
// Several producers share one consumer through a single output register.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     per-channel handshake (in_ready only for grant)
//   in_data               channel i at in_data[i*W +: W]
//   out_valid/out_ready   output handshake
//   out_data, out_sel     registered word and its one-hot source channel
// Build option: define RR_BUS_MUX_RR_EN for round-robin arbitration;
// without it, the lowest-index valid channel always wins.
module rr_bus_mux #(
    parameter int NCH = 3,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic [NCH-1:0]   out_sel
);

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [NCH-1:0] out_sel_q, out_sel_d;

    logic           load_en;
    logic           xfer;
    logic [NCH-1:0] grant;
    logic [W-1:0]   grant_data;

`ifdef RR_BUS_MUX_RR_EN
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW:0]   NCH_W = (PW+1)'(NCH);
    localparam logic [PW-1:0] LAST  = PW'(NCH - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cand;
    logic [PW-1:0] win;

    // Walk the channels from the pointer backwards so the last hit,
    // i.e. the first valid channel at or after the pointer, wins.
    always_comb begin
        win  = ptr_q;
        cand = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= NCH_W) begin
                cand = cand - NCH_W;
            end
            if (in_valid[cand[PW-1:0]]) begin
                win = cand[PW-1:0];
            end
        end
        grant = '0;
        if (|in_valid) begin
            grant[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (win == LAST) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Isolate the lowest set bit: fixed priority, channel 0 first.
    always_comb begin
        grant = in_valid & (~in_valid + 1'b1);
    end
`endif

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;

    // rst_n gate keeps producers from seeing a handshake during reset.
    assign in_ready = (load_en && rst_n) ? grant : '0;
    assign xfer     = |in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_sel_d   = grant;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_sel_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
